// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage with 16x oversampling, 3-sample
// majority vote at mid-bit, framing/overrun detection and a valid/ready
// output handshake.
// Optional: define UART_RX_PARITY_EN to add an even-parity bit between the
// data bits and the stop bit (parity_err reports mismatches).
module uart_receiver #(
  parameter int unsigned CLK_FREQ  = 10_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned OVS_DIV   = CLK_FREQ / (BAUD_RATE * 16)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned PRESC_W = $clog2(OVS_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(OVS_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic               rx_meta, rx_s;
  logic [1:0]         warm;
  logic               armed;
  logic [PRESC_W-1:0] presc;
  logic [3:0]         samp;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_q;
  logic               s7, s8;

  logic tick_c, mid_c, end_c, maj_c;
  logic start_c, shift_c, load_c, frame_c, overrun_c;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_cap_c, parity_c, par_bad_c;
`endif

  assign tick_c = (state != S_IDLE) && (presc == PRESC_MAX);
  assign mid_c  = tick_c && (samp == 4'd9);
  assign end_c  = tick_c && (samp == 4'd15);
  assign maj_c  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
`ifdef UART_RX_PARITY_EN
  assign par_bad_c = ^{shift_q, par_q};
`endif

  // Two-flop synchroniser; warm marks when rx_s reflects the real line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      warm    <= 2'b00;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      warm    <= {warm[0], 1'b1};
    end
  end

  // Arm start detection only after the line has been seen high in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (start_c || (state != S_IDLE)) begin
      armed <= 1'b0;
    end else if (warm[1] && rx_s) begin
      armed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle event decode
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    shift_c   = 1'b0;
    load_c    = 1'b0;
    frame_c   = 1'b0;
    overrun_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap_c = 1'b0;
    parity_c  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (armed && !rx_s) begin
          start_c   = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (mid_c && maj_c)  state_nxt = S_IDLE;
        else if (end_c)      state_nxt = S_DATA;
      end
      S_DATA: begin
        if (mid_c) shift_c = 1'b1;
        if (end_c && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid_c) par_cap_c = 1'b1;
        if (end_c) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (mid_c) begin
          state_nxt = S_IDLE;
          if (!maj_c)                      frame_c   = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bad_c)              parity_c  = 1'b1;
`endif
          else if (rx_valid && !rx_ready)  overrun_c = 1'b1;
          else                             load_c    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Prescaler, sample counter, bit index and majority sample capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      samp    <= 4'd0;
      bit_idx <= 3'd0;
      s7      <= 1'b0;
      s8      <= 1'b0;
    end else begin
      if (state == S_IDLE || tick_c) presc <= '0;
      else                           presc <= presc + PRESC_W'(1);
      if (state == S_IDLE)  samp <= 4'd0;
      else if (tick_c)      samp <= samp + 4'd1;
      if (state == S_START)             bit_idx <= 3'd0;
      else if (state == S_DATA && end_c) bit_idx <= bit_idx + 3'd1;
      if (tick_c && samp == 4'd7) s7 <= rx_s;
      if (tick_c && samp == 4'd8) s8 <= rx_s;
    end
  end

  // Data shift register, LSB received first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       shift_q <= 8'h00;
    else if (shift_c) shift_q <= {maj_c, shift_q[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  // Parity bit capture and mismatch pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_cap_c) par_q <= maj_c;
      parity_err <= parity_c;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Output byte, handshake and status registers; a load beats a consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (load_c) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      frame_err   <= frame_c;
      overrun_err <= overrun_c;
      busy        <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (OVS_DIV=10, 160 clocks per bit).
module tb_uart_receiver;

  localparam int unsigned OVS = 10;
  localparam int          BIT = 16 * OVS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_receiver #(.OVS_DIV(OVS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int valid_hi = 0, fe_hi = 0, ov_hi = 0, pe_hi = 0, got = 0;

  // Monitor: pulse accounting and scoreboard pop on every consume
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid)    valid_hi++;
      if (frame_err)   fe_hi++;
      if (overrun_err) ov_hi++;
      if (parity_err)  pe_hi++;
      if (rx_valid && rx_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deliver: got byte %02h, expected no byte", rx_data);
        end else begin
          exp_byte = exp_q.pop_front();
          if (rx_data !== exp_byte) begin
            errors++;
            $display("FAIL deliver: got %02h, expected %02h", rx_data, exp_byte);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic v);
    @(posedge clk); #1;
    rx = v;
    repeat (BIT - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  task automatic idle(input int n);
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, expected 000", {frame_err, overrun_err, parity_err});
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic;
    int g0, v0, f0;
    g0 = got; v0 = valid_hi; f0 = fe_hi;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(BIT);
    checks++; if (got - g0 != 1) begin errors++; $display("FAIL basic_count: got %0d bytes, expected 1", got - g0); end
    checks++; if (valid_hi - v0 != 1) begin errors++; $display("FAIL basic_valid_width: got %0d cycles, expected 1", valid_hi - v0); end
    checks++; if (fe_hi != f0) begin errors++; $display("FAIL basic_frame_err: got %0d pulses, expected 0", fe_hi - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_false_start;
    int g0, e0;
    g0 = got; e0 = fe_hi + ov_hi + pe_hi;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (10) @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b, expected 1", busy); end
    repeat (50) @(posedge clk);
    idle(2 * BIT);
    checks++; if (got != g0) begin errors++; $display("FAIL glitch_count: got %0d bytes, expected 0", got - g0); end
    checks++; if (fe_hi + ov_hi + pe_hi != e0) begin errors++; $display("FAIL glitch_flags: got %0d pulses, expected 0", fe_hi + ov_hi + pe_hi - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b, expected 0", busy); end
  endtask

  task automatic test_frame_err;
    int g0, f0;
    g0 = got; f0 = fe_hi;
    send_frame(8'h3C, 1'b0);
    repeat (20 * BIT) @(posedge clk);
    #1;
    checks++; if (fe_hi - f0 != 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles, expected 1", fe_hi - f0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_valid: got %b, expected 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b, expected 0", busy); end
    idle(2 * BIT);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(BIT);
    checks++; if (got - g0 != 1) begin errors++; $display("FAIL break_recover_count: got %0d bytes, expected 1", got - g0); end
    checks++; if (fe_hi - f0 != 1) begin errors++; $display("FAIL break_frame_err: got %0d cycles, expected 1", fe_hi - f0); end
  endtask

  task automatic test_overrun;
    int o0, f0;
    o0 = ov_hi; f0 = fe_hi;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(BIT);
    send_frame(8'h22, 1'b1);
    idle(BIT);
    #1;
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_data: got %02h, expected 11", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b, expected 1", rx_valid); end
    checks++; if (ov_hi - o0 != 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles, expected 1", ov_hi - o0); end
    checks++; if (fe_hi != f0) begin errors++; $display("FAIL overrun_frame_err: got %0d, expected 0", fe_hi - f0); end
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL consume_clear: got %b, expected 0", rx_valid); end
    rx_ready = 1'b1;
  endtask

  task automatic test_reset_midframe;
    int g0, e0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (80) @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midreset_data: got %02h, expected 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    rst_n = 1'b1;
    g0 = got; e0 = fe_hi + ov_hi + pe_hi;
    repeat (2 * BIT) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL low_after_reset_busy: got %b, expected 0", busy); end
    idle(2 * BIT);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1);
    idle(BIT);
    checks++; if (got - g0 != 1) begin errors++; $display("FAIL midreset_count: got %0d bytes, expected 1", got - g0); end
    checks++; if (fe_hi + ov_hi + pe_hi != e0) begin errors++; $display("FAIL midreset_flags: got %0d pulses, expected 0", fe_hi + ov_hi + pe_hi - e0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int g0, p0;
    g0 = got; p0 = pe_hi;
    exp_q.push_back(8'h07);
    send_frame_par(8'h07, 1'b1);
    idle(BIT);
    checks++; if (got - g0 != 1) begin errors++; $display("FAIL parity_ok_count: got %0d bytes, expected 1", got - g0); end
    send_frame_par(8'h07, 1'b0);
    idle(BIT);
    checks++; if (pe_hi - p0 != 1) begin errors++; $display("FAIL parity_err_pulse: got %0d cycles, expected 1", pe_hi - p0); end
    checks++; if (got - g0 != 1) begin errors++; $display("FAIL parity_bad_count: got %0d bytes, expected 1", got - g0); end
  endtask
`endif

  initial begin
    rx = 1'b1;
    rx_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d bytes outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
